// File: rtl/kernel_pkg.sv
// Shared types and reset-kernel definition for the convolution kernel loader.
package kernel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } loader_state_t;

    localparam int DEFAULT_SIZE = 3;
    localparam int DEFAULT_KERNEL_WIDTH = 8;

    // Vertical gradient {-1,-2,-1; 0,0,0; 1,2,1} for 3x3, all zeros otherwise.
    function automatic int default_coef(
        input int row,
        input int col,
        input int size
    );
        int mag;
        mag = (col == 1) ? 2 : 1;
        if (size != 3) return 0;
        if (row == 0) return -mag;
        if (row == 2) return mag;
        return 0;
    endfunction

endpackage

// File: rtl/kernel_bank.sv
// SIZE x SIZE signed coefficient register array with indexed write and bulk load.
module kernel_bank
    import kernel_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int KERNEL_WIDTH = DEFAULT_KERNEL_WIDTH,
    parameter int IW = $clog2(SIZE * SIZE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [IW-1:0]                  wr_idx,
    input  logic signed [KERNEL_WIDTH-1:0] wr_data,
    input  logic                           load_en,
    input  logic signed [KERNEL_WIDTH-1:0] load_data [SIZE][SIZE],
    output logic signed [KERNEL_WIDTH-1:0] q [SIZE][SIZE]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    q[r][c] <= KERNEL_WIDTH'(default_coef(r, c, SIZE));
                end
            end
        end else if (load_en) begin
            q <= load_data;
        end else if (wr_en) begin
            // Row-major index decode: slot (r,c) owns index r*SIZE+c.
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (wr_idx == IW'(r * SIZE + c)) begin
                        q[r][c] <= wr_data;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/kernel_stream_loader.sv
// Serial kernel loader with shadow bank committed at frame boundaries.
// Optional KERNEL_SUM_EN macro enables the registered coefficient sum.
module kernel_stream_loader
    import kernel_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int KERNEL_WIDTH = DEFAULT_KERNEL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           coef_valid,
    output logic                           coef_ready,
    input  logic signed [KERNEL_WIDTH-1:0] coef_data,
    input  logic                           coef_last,
    input  logic                           frame_start,
    output logic signed [KERNEL_WIDTH-1:0] kernel [SIZE][SIZE],
    output logic                           kernel_update,
    output logic                           load_error,
    output logic signed [KERNEL_WIDTH+$clog2(SIZE*SIZE)-1:0] kernel_sum
);

    localparam int N = SIZE * SIZE;
    localparam int IW = $clog2(N);
    localparam int SW = KERNEL_WIDTH + IW;

    loader_state_t state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic xfer;
    logic commit;
    logic error;
    logic at_end;
    logic signed [KERNEL_WIDTH-1:0] shadow_q [SIZE][SIZE];

    assign at_end = (index_q == IW'(N - 1));

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        commit = 1'b0;
        error = 1'b0;
        coef_ready = (state_q != PENDING);
        xfer = coef_valid && coef_ready;
        unique case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    if (coef_last && at_end) begin
                        state_d = PENDING;
                        index_d = '0;
                    end else if (coef_last || at_end) begin
                        error = 1'b1;
                        state_d = IDLE;
                        index_d = '0;
                    end else begin
                        state_d = LOAD;
                        index_d = index_q + 1'b1;
                    end
                end
            end
            PENDING: begin
                if (frame_start) begin
                    commit = 1'b1;
                    state_d = IDLE;
                    index_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            kernel_update <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            kernel_update <= commit;
            load_error <= error;
        end
    end

    kernel_bank #(
        .SIZE(SIZE),
        .KERNEL_WIDTH(KERNEL_WIDTH),
        .IW(IW)
    ) u_shadow (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(xfer),
        .wr_idx(index_q),
        .wr_data(coef_data),
        .load_en(1'b0),
        .load_data(kernel),
        .q(shadow_q)
    );

    kernel_bank #(
        .SIZE(SIZE),
        .KERNEL_WIDTH(KERNEL_WIDTH),
        .IW(IW)
    ) u_active (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(1'b0),
        .wr_idx('0),
        .wr_data('0),
        .load_en(commit),
        .load_data(shadow_q),
        .q(kernel)
    );

`ifdef KERNEL_SUM_EN
    logic signed [SW-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                sum_d = sum_d + SW'(shadow_q[r][c]);
            end
        end
    end

    // Every default kernel sums to zero, so reset to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kernel_sum <= '0;
        end else if (commit) begin
            kernel_sum <= sum_d;
        end
    end
`else
    assign kernel_sum = '0;
`endif

endmodule

// File: tb/tb_kernel_stream_loader.sv
// Scoreboard bench for kernel_stream_loader with a queue-based load/commit model.
module tb_kernel_stream_loader;

    localparam int SIZE = 3;
    localparam int KW = 8;
    localparam int N = SIZE * SIZE;
    localparam int SW = KW + $clog2(N);

    typedef logic signed [KW-1:0] coef_t;
    typedef logic [N*KW-1:0] flat_t;
    typedef struct packed {
        logic upd;
        int cyc;
        flat_t k;
        int sum;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic coef_valid = 1'b0;
    logic coef_ready;
    coef_t coef_data = '0;
    logic coef_last = 1'b0;
    logic frame_start = 1'b0;
    coef_t kernel [SIZE][SIZE];
    logic kernel_update;
    logic load_error;
    logic signed [SW-1:0] kernel_sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ev_t exp_q[$];
    ev_t ev;
    coef_t got_q[$];
    flat_t pend_f;
    int pend_sum;
    bit pend;
    flat_t act_f;
    flat_t dflt_f;
    int dflt [N] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    bit x;

    kernel_stream_loader #(
        .SIZE(SIZE),
        .KERNEL_WIDTH(KW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .coef_data(coef_data),
        .coef_last(coef_last),
        .frame_start(frame_start),
        .kernel(kernel),
        .kernel_update(kernel_update),
        .load_error(load_error),
        .kernel_sum(kernel_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic flat_t dut_flat();
        flat_t f;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                f[(r*SIZE+c)*KW +: KW] = kernel[r][c];
        return f;
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic chk_flat(input string name, input flat_t act,
                            input flat_t req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic check_kernel(input string name);
        chk_flat(name, dut_flat(), act_f);
    endtask

    // One clock of stimulus; model decides acceptance from its own state.
    task automatic step(input bit v, input coef_t d, input bit l,
                        input bit fs, output bit xfer);
        bit commit;
        bit done;
        bit err;
        ev_t e;
        coef_valid = v;
        coef_data = d;
        coef_last = l;
        frame_start = fs;
        chk("coef_ready", coef_ready, !pend);
        xfer = v && !pend;
        commit = fs && pend;
        done = 0;
        err = 0;
        if (xfer) begin
            got_q.push_back(d);
            if (l && got_q.size() == N) done = 1;
            else if (l || got_q.size() == N) err = 1;
        end
        if (commit) begin
            e.upd = 1;
            e.cyc = cyc + 1;
            e.k = pend_f;
`ifdef KERNEL_SUM_EN
            e.sum = pend_sum;
`else
            e.sum = 0;
`endif
            exp_q.push_back(e);
        end
        if (err) begin
            e.upd = 0;
            e.cyc = cyc + 1;
            e.k = '0;
            e.sum = 0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (commit) begin
            act_f = pend_f;
            pend = 0;
        end
        if (done) begin
            pend_sum = 0;
            for (int i = 0; i < N; i++) begin
                pend_f[i*KW +: KW] = got_q[i];
                pend_sum += int'(got_q[i]);
            end
            pend = 1;
        end
        if (done || err) got_q.delete();
        coef_valid = 0;
        frame_start = 0;
        coef_last = 0;
    endtask

    task automatic do_reset(input int hold);
        rst_n = 0;
        #1;
        exp_q.delete();
        got_q.delete();
        pend = 0;
        act_f = dflt_f;
        chk_flat("reset_kernel", dut_flat(), dflt_f);
        chk("reset_ready", coef_ready, 1);
        chk("reset_update", kernel_update, 0);
        chk("reset_error", load_error, 0);
        chk("reset_sum", kernel_sum, 0);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic offer(input coef_t d, input bit l);
        bit got;
        bit dummy;
        int tries;
        got = 0;
        tries = 0;
        while (!got) begin
            if ($urandom_range(0, 3) == 0)
                step(0, coef_t'($urandom), 0,
                     $urandom_range(0, 3) == 0, dummy);
            step(1, d, l, $urandom_range(0, 3) == 0, got);
            tries++;
            if (tries > 200) begin
                chk("offer_timeout", tries, 200);
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_pulse_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (kernel_update || load_error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse",
                        {kernel_update, load_error}, 0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("pulse_update", kernel_update, ev.upd);
                    chk("pulse_error", load_error, !ev.upd);
                    chk("pulse_cycle", cyc, ev.cyc);
                    if (ev.upd) begin
                        chk_flat("commit_kernel", dut_flat(), ev.k);
                        chk("commit_sum", kernel_sum, ev.sum);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++)
            dflt_f[i*KW +: KW] = coef_t'(dflt[i]);
        act_f = dflt_f;
        pend = 0;
        pend_f = '0;
        pend_sum = 0;
        #1;
        do_reset(3);
        check_kernel("t1_kernel");

        for (int i = 1; i <= N; i++) step(1, coef_t'(i), i == N, 0, x);
        step(0, 0, 0, 1, x);
        check_kernel("t2_kernel");
`ifdef KERNEL_SUM_EN
        chk("t2_sum", kernel_sum, 45);
`endif
        step(0, 0, 0, 0, x);

        for (int i = 1; i <= 4; i++) step(1, coef_t'(10 + i), i == 4, 0, x);
        step(0, 0, 0, 1, x);
        step(0, 0, 0, 0, x);
        check_kernel("t3_kept");
        for (int i = 1; i <= N; i++) step(1, 2, i == N, 0, x);
        step(0, 0, 0, 1, x);
        step(0, 0, 0, 0, x);
        check_kernel("t3_twos");

        for (int i = 1; i <= N; i++) step(1, coef_t'(-i), 0, 0, x);
        step(0, 0, 0, 1, x);
        step(0, 0, 0, 0, x);
        check_kernel("t4_kept");

        for (int i = 1; i <= N; i++) step(1, coef_t'(3 * i), i == N, i == N, x);
        step(0, 0, 0, 0, x);
        check_kernel("t5_no_commit");
        repeat (3) step(1, 77, 0, 0, x);
        step(0, 0, 0, 1, x);
        step(0, 0, 0, 0, x);
        check_kernel("t5_commit");

        for (int i = 1; i <= 5; i++) step(1, coef_t'(50 + i), 0, 0, x);
        do_reset(2);
        step(0, 0, 0, 1, x);
        check_kernel("t6_mid_load");
        for (int i = 1; i <= N; i++) step(1, coef_t'(-20 * i), i == N, 0, x);
        do_reset(2);
        step(0, 0, 0, 1, x);
        step(0, 0, 0, 0, x);
        check_kernel("t6_pending");

        repeat (60) begin
            case ($urandom_range(0, 3))
                0: for (int i = 1; i <= N; i++)
                    offer(coef_t'($urandom), i == N);
                1: begin
                    int len;
                    len = $urandom_range(1, N - 1);
                    for (int i = 1; i <= len; i++)
                        offer(coef_t'($urandom), i == len);
                end
                2: for (int i = 1; i <= N; i++)
                    offer(coef_t'($urandom), 0);
                default: repeat ($urandom_range(1, 4))
                    step(0, 0, 0, $urandom_range(0, 1) == 1, x);
            endcase
            check_kernel("rand_kernel");
        end

        step(0, 0, 0, 1, x);
        repeat (3) step(0, 0, 0, 0, x);
        check_kernel("final_kernel");
        chk("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
